// File: rtl/tof_pkg.sv
// Shared types and width/slice helpers for the time-of-flight ping averager.
package tof_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int acc_width(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

    function automatic int hit_width(input int avg_log2);
        return avg_log2 + 1;
    endfunction

    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/tof_chan_capture.sv
// One echo channel: first/last capture within a ping and burst accumulation.
module tof_chan_capture
    import tof_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int AVG_LOG2 = 2,
    localparam int ACC_W   = acc_width(CNT_W, AVG_LOG2),
    localparam int HIT_W   = hit_width(AVG_LOG2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] win,
    input  logic             win_ok,
    input  logic             rx,
    input  logic             end_of_ping,
    input  logic             end_of_burst,
    input  logic             clear,
    output logic [ACC_W-1:0] sum_first,
    output logic [ACC_W-1:0] sum_last,
    output logic [HIT_W-1:0] hits
);

    logic             accept;
    logic             hit_p0;
    logic [CNT_W-1:0] first_p0;
    logic [CNT_W-1:0] last_p0;
    logic [ACC_W-1:0] acc_first;
    logic [ACC_W-1:0] acc_last;
    logic [HIT_W-1:0] acc_hits;

    logic             hit_now;
    logic [CNT_W-1:0] first_now;
    logic [CNT_W-1:0] last_now;

    assign accept = win_ok & rx;

    // Ping-inclusive view: an echo on the final window cycle still counts.
    assign hit_now   = hit_p0 | accept;
    assign first_now = hit_p0 ? first_p0 : win;
    assign last_now  = accept ? win : last_p0;

    assign sum_first = acc_first + (hit_now ? {{AVG_LOG2{1'b0}}, first_now} : '0);
    assign sum_last  = acc_last  + (hit_now ? {{AVG_LOG2{1'b0}}, last_now}  : '0);
    assign hits      = acc_hits  + {{AVG_LOG2{1'b0}}, hit_now};

    // ---- capture / accumulate stage ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_p0    <= 1'b0;
            first_p0  <= '0;
            last_p0   <= '0;
            acc_first <= '0;
            acc_last  <= '0;
            acc_hits  <= '0;
        end else if (end_of_ping) begin
            hit_p0   <= 1'b0;
            first_p0 <= '0;
            last_p0  <= '0;
            if (end_of_burst) begin
                acc_first <= '0;
                acc_last  <= '0;
                acc_hits  <= '0;
            end else begin
                acc_first <= sum_first;
                acc_last  <= sum_last;
                acc_hits  <= hits;
            end
        end else if (accept) begin
            hit_p0  <= 1'b1;
            last_p0 <= win;
            if (!hit_p0) begin
                first_p0 <= win;
            end
        end
    end

endmodule

// File: rtl/tof_ping_averager.sv
// Ping/echo time-of-flight engine averaging over bursts of 2^AVG_LOG2 pings.
// Optional echo acceptance gate enabled by defining TOF_ECHO_GATE_EN.
module tof_ping_averager
    import tof_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CNT_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int BLANK    = 16,
    localparam int ACC_W   = acc_width(CNT_W, AVG_LOG2),
    localparam int HIT_W   = hit_width(AVG_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_W-1:0]     period,
`ifdef TOF_ECHO_GATE_EN
    input  logic [CNT_W-1:0]     gate_lo,
    input  logic [CNT_W-1:0]     gate_hi,
`endif
    input  logic [NCH-1:0]       rx_stb,
    output logic                 tx_stb,
    output logic                 busy,
    output logic                 res_valid,
    output logic [NCH*ACC_W-1:0] res_first,
    output logic [NCH*ACC_W-1:0] res_last,
    output logic [NCH*HIT_W-1:0] res_hits
);

    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(BLANK + 2);
    localparam logic [CNT_W-1:0] BLANK_W    = CNT_W'(BLANK);

    state_t                state;
    state_t                state_nxt;
    logic                  run;
    logic                  go;
    logic [CNT_W-1:0]      eff_period;
    logic [CNT_W-1:0]      win;
    logic [AVG_LOG2-1:0]   pidx;
    logic                  end_of_ping;
    logic                  end_of_burst;
    logic                  win_ok;
    logic [NCH*ACC_W-1:0]  sum_first_all;
    logic [NCH*ACC_W-1:0]  sum_last_all;
    logic [NCH*HIT_W-1:0]  hits_all;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = RUN;
            RUN:     if (stop)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign run          = (state == RUN);
    assign go           = (state == IDLE) && start && !stop;
    assign end_of_ping  = run && (win == eff_period - 1'b1);
    assign end_of_burst = end_of_ping && (pidx == {AVG_LOG2{1'b1}});
    assign tx_stb       = run && (win == '0);
    assign busy         = run;

`ifdef TOF_ECHO_GATE_EN
    logic [CNT_W-1:0] lo_bound;
    logic [CNT_W-1:0] hi_bound;

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_bound <= '0;
            hi_bound <= '0;
        end else if (go) begin
            lo_bound <= (gate_lo > BLANK_W) ? gate_lo : BLANK_W;
            hi_bound <= gate_hi;
        end
    end

    assign win_ok = run && (win >= lo_bound) && (win <= hi_bound);
`else
    assign win_ok = run && (win >= BLANK_W);
`endif

    // ---- control stage: FSM, period latch, window/ping counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            eff_period <= MIN_PERIOD;
            win        <= '0;
            pidx       <= '0;
        end else begin
            state <= state_nxt;
            if (go) begin
                eff_period <= (period < MIN_PERIOD) ? MIN_PERIOD : period;
                win        <= '0;
                pidx       <= '0;
            end else if (run) begin
                if (stop) begin
                    win  <= '0;
                    pidx <= '0;
                end else if (end_of_ping) begin
                    win  <= '0;
                    pidx <= pidx + 1'b1;
                end else begin
                    win <= win + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        tof_chan_capture #(
            .CNT_W    (CNT_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .win          (win),
            .win_ok       (win_ok),
            .rx           (rx_stb[c]),
            .end_of_ping  (end_of_ping),
            .end_of_burst (end_of_burst),
            .clear        (!run),
            .sum_first    (sum_first_all[slice_lo(c, ACC_W) +: ACC_W]),
            .sum_last     (sum_last_all[slice_lo(c, ACC_W) +: ACC_W]),
            .hits         (hits_all[slice_lo(c, HIT_W) +: HIT_W])
        );
    end

    // ---- result stage: snapshot of the completed burst ----
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_first <= '0;
            res_last  <= '0;
            res_hits  <= '0;
        end else begin
            res_valid <= end_of_burst;
            if (end_of_burst) begin
                res_first <= sum_first_all;
                res_last  <= sum_last_all;
                res_hits  <= hits_all;
            end
        end
    end

endmodule

// File: tb/tb_tof_ping_averager.sv
// Directed self-checking bench for tof_ping_averager with default parameters.
module tb_tof_ping_averager;

    localparam int NCH   = 2;
    localparam int CNT_W = 12;
    localparam int ACC_W = 14;
    localparam int HIT_W = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 stop;
    logic [CNT_W-1:0]     period;
    logic [NCH-1:0]       rx_stb;
    logic                 tx_stb;
    logic                 busy;
    logic                 res_valid;
    logic [NCH*ACC_W-1:0] res_first;
    logic [NCH*ACC_W-1:0] res_last;
    logic [NCH*HIT_W-1:0] res_hits;
`ifdef TOF_ECHO_GATE_EN
    logic [CNT_W-1:0]     gate_lo = '0;
    logic [CNT_W-1:0]     gate_hi = '1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tof_ping_averager dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
`ifdef TOF_ECHO_GATE_EN
        .gate_lo   (gate_lo),
        .gate_hi   (gate_hi),
`endif
        .rx_stb    (rx_stb),
        .tx_stb    (tx_stb),
        .busy      (busy),
        .res_valid (res_valid),
        .res_first (res_first),
        .res_last  (res_last),
        .res_hits  (res_hits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_res(input int f0, input int l0, input int h0, input logic vld);
        chk("res_valid", res_valid, vld);
        chk("res_first0", res_first[ACC_W-1:0], f0);
        chk("res_last0", res_last[ACC_W-1:0], l0);
        chk("res_hits0", res_hits[HIT_W-1:0], h0);
        chk("res_first1", res_first[2*ACC_W-1:ACC_W], 0);
        chk("res_last1", res_last[2*ACC_W-1:ACC_W], 0);
        chk("res_hits1", res_hits[2*HIT_W-1:HIT_W], 0);
    endtask

    // Entered at window 0 of ping 0; drives ch0 echoes at e0/e1/e2 in pings
    // selected by pmask, and optionally pulses start or stop at a given point.
    task automatic run_burst(input int eff, input int e0, input int e1, input int e2,
                             input logic [3:0] pmask, input logic vld0,
                             input int stop_p, input int stop_w, input int start_w);
        for (int p = 0; p < 4; p++) begin
            for (int w = 0; w < eff; w++) begin
                chk("tx_stb", tx_stb, (w == 0));
                chk("res_valid_run", res_valid, vld0 && p == 0 && w == 0);
                chk("busy_run", busy, 1'b1);
                rx_stb = {1'b0, pmask[p] && (w == e0 || w == e1 || w == e2)};
                start  = (p == 0 && w == start_w);
                stop   = (p == stop_p && w == stop_w);
                tick();
                if (stop) begin
                    stop   = 1'b0;
                    start  = 1'b0;
                    rx_stb = '0;
                    return;
                end
            end
        end
        rx_stb = '0;
        start  = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        period = 12'd100;
        rx_stb = '0;
        repeat (3) tick();
        chk("rst_tx", tx_stb, 0);
        chk("rst_busy", busy, 0);
        check_res(0, 0, 0, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Single echo at 40 every ping
        start = 1'b1;
        tick();
        start = 1'b0;
        run_burst(100, 40, -1, -1, 4'hf, 1'b0, -1, -1, -1);
        check_res(160, 160, 4, 1'b1);

        // Echoes at 10 (blanked), 30, 55; start while busy and a period change are ignored
        period = 12'd5;
        run_burst(100, 10, 30, 55, 4'hf, 1'b1, -1, -1, 3);
        check_res(120, 220, 4, 1'b1);

        run_burst(100, -1, -1, -1, 4'h0, 1'b1, -1, -1, -1);
        check_res(0, 0, 0, 1'b1);

        run_burst(100, 50, -1, -1, 4'b1010, 1'b1, -1, -1, -1);
        check_res(100, 100, 2, 1'b1);

        // Stop at ping 2, window 30: partial burst discarded
        run_burst(100, 40, -1, -1, 4'hf, 1'b1, 2, 30, -1);
        chk("stop_busy", busy, 0);
        chk("stop_tx", tx_stb, 0);
        for (int i = 0; i < 150; i++) begin
            chk("stopped_tx", tx_stb, 0);
            chk("stopped_vld", res_valid, 0);
            tick();
        end
        check_res(100, 100, 2, 1'b0);

        // period=5 clamps to 18; echo on the final window cycle is included
        period = 12'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("first_tx", tx_stb, 1);
        run_burst(18, 17, -1, -1, 4'hf, 1'b0, -1, -1, -1);
        check_res(68, 68, 4, 1'b1);

        // Reset mid-run
        repeat (25) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx", tx_stb, 0);
        chk("midrst_busy", busy, 0);
        check_res(0, 0, 0, 1'b0);

        // start and stop together stay idle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ss_busy", busy, 0);
            chk("ss_tx", tx_stb, 0);
            tick();
        end

        // Clean restart; echo at 15 is blanked, 16 is the first accepted window
        period = 12'd20;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_tx", tx_stb, 1);
        chk("restart_busy", busy, 1);
        run_burst(20, 15, 16, 19, 4'hf, 1'b0, -1, -1, -1);
        check_res(64, 76, 4, 1'b1);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("final_busy", busy, 0);
        chk("final_tx", tx_stb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
